multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore control FSM for the 16-bit multi-cycle datapath. Sits directly upstream of the ALU/calculation stage.
//  Decodes IR[15:12] and sequences FETCH/DECODE/EXEC/MEM/WB. Drives ALUSrcA/B, ALUOp, PCSrc and all write enables.
//  Consumes the ALU Zero/negative flags to resolve branches. Stalls on a memory ready handshake.
// PARAMETERS
//  INSTR_W      16   instruction width; opcode = instr[INSTR_W-1 -:4], funct = instr[2:0]
//  CNT_W        16   width of retired-instruction counter
//  MEM_TIMEOUT  255  max wait cycles in a memory state before error halt
// PORTS
//  clk               in   1   single clock, rising edge
//  reset             in   1   asynchronous, active-high
//  input_instr       in   16  IR contents (valid from DECODE onward)
//  input_Zero        in   1   ALU zero flag (combinational, same cycle)
//  input_negative    in   1   ALU negative flag
//  input_mem_ready   in   1   memory completes access this cycle
//  output_PCWrite    out  1   unconditional PC load
//  output_IRWrite    out  1   IR load
//  output_IorD       out  1   0=PC addresses memory, 1=ALUOut
//  output_MemRead    out  1   memory read request
//  output_MemWrite   out  1   memory write request
//  output_RegWrite   out  1   register file write
//  output_MemtoReg   out  1   0=ALUOut, 1=MDR to register file
//  output_ALUSrcA    out  2   0=PC, 1=const 2, 2=A reg
//  output_ALUSrcB    out  2   0=B reg, 1=const 2, 2=imm
//  output_ALUOp      out  3   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SLT
//  output_PCSrc      out  1   0=live ALU result, 1=ALUOut
//  output_halted     out  1   FSM in HALT
//  output_illegal    out  1   sticky illegal-opcode flag
//  output_mem_err    out  1   sticky memory-timeout flag
//  output_instr_count out CNT_W  retired instructions
// BEHAVIOUR
//  - Reset (async): state=FETCH, wait cnt=0, count=0, flags=0. All enables/requests forced 0 while reset high.
//    Mux selects and ALUOp are 0 during reset.
//  - Opcodes: 0 R-type (ALUOp=funct), 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BLT, 6 JMP, F HALT, 7-E illegal.
//  - FETCH: MemRead=1, IorD=0, SrcA=0, SrcB=1, ALUOp=ADD, PCSrc=0.
//    PCWrite/IRWrite asserted only in the cycle mem_ready=1; advance to DECODE then.
//  - DECODE (1 cycle): SrcA=0, SrcB=2, ADD -> ALUOut=PC+2+imm (branch/jump target).
//    Next state by opcode: R->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BLT->BRANCH, JMP->JUMP, F->HALT.
//  - EXEC_R: SrcA=2, SrcB=0, ALUOp=funct -> ALU_WB.  EXEC_I: SrcA=2, SrcB=2, ADD -> ALU_WB.
//  - ALU_WB: RegWrite=1, MemtoReg=0 -> FETCH.  MEM_ADDR: SrcA=2, SrcB=2, ADD -> MEM_RD (LW) or MEM_WR (SW).
//  - MEM_RD: MemRead=1, IorD=1; hold until mem_ready, then MEM_WB (RegWrite=1, MemtoReg=1) -> FETCH.
//  - MEM_WR: MemWrite=1, IorD=1; hold until mem_ready -> FETCH.
//  - BRANCH: SrcA=2, SrcB=0, SUB, PCSrc=1. PCWrite=Zero (BEQ) or negative (BLT), same cycle -> FETCH.
//  - JUMP: PCSrc=1, PCWrite=1 -> FETCH.
//  - HALT: terminal, all enables 0, halted=1; exit only by reset.
//  - Wait counter: clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0.
//    When it reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1, go to HALT.
//    mem_ready=1 on the timeout cycle wins (access completes).
//  - instr_count +1 on the final cycle of each instruction (ALU_WB, MEM_WB, MEM_WR done, BRANCH, JUMP).
//    Wraps at 2^CNT_W; HALT is not counted.
//  - Reset mid-instruction aborts immediately; no write enable is emitted in the reset cycle.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:
//    opcode 7-E in DECODE -> HALT, illegal=1 (sticky until reset).
//  CTRL_ILLEGAL_TRAP_EN undefined:
//    opcode 7-E treated as NOP: DECODE -> FETCH, counted as retired, illegal tied 0.
// TESTING
//  1 Reset in DECODE: all enables 0 at once; after release FETCH issues MemRead=1, SrcA=0, SrcB=1.
//  2 ADD R-type (0x0xx0), mem_ready=1: states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 in cycle 4; count=1.
//  3 LW with mem_ready low 3 cycles: MEM_RD holds 3 cycles, MEM_WB MemtoReg=1, RegWrite=1 once.
//  4 BEQ Zero=1 -> PCWrite=1, PCSrc=1. BEQ Zero=0 -> PCWrite=0. BLT negative=1 -> PCWrite=1.
//  5 mem_ready held 0 in FETCH for MEM_TIMEOUT cycles -> mem_err=1, halted=1, no PCWrite.
//  6 Opcode 0x9: with CTRL_ILLEGAL_TRAP_EN -> halted=1, illegal=1; without -> back to FETCH, count+1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Moore control FSM for the 16-bit multi-cycle datapath. It decodes the
//   opcode in IR[15:12] and sequences FETCH/DECODE/EXEC/MEM/WB. It drives
//   the ALU operand selects, the ALU operation, the PC source and every
//   write enable. Branches are resolved from the ALU Zero/negative flags.
//   Memory states stall on input_mem_ready and give up after MEM_TIMEOUT
//   wait cycles.
//   Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt on opcodes 7-E.
//   Without it, opcodes 7-E retire as NOPs.
module multicycle_control_fsm #(
    parameter int INSTR_W     = 16,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] input_instr,
    input  logic               input_Zero,
    input  logic               input_negative,
    input  logic               input_mem_ready,
    output logic               output_PCWrite,
    output logic               output_IRWrite,
    output logic               output_IorD,
    output logic               output_MemRead,
    output logic               output_MemWrite,
    output logic               output_RegWrite,
    output logic               output_MemtoReg,
    output logic [1:0]         output_ALUSrcA,
    output logic [1:0]         output_ALUSrcB,
    output logic [2:0]         output_ALUOp,
    output logic               output_PCSrc,
    output logic               output_halted,
    output logic               output_illegal,
    output logic               output_mem_err,
    output logic [CNT_W-1:0]   output_instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // Value of the wait counter on the last wait cycle before a timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BLT   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] SRC_A_REG = 2'd2;
    localparam logic [1:0] SRC_B_TWO = 2'd1;
    localparam logic [1:0] SRC_B_IMM = 2'd2;
    localparam logic [2:0] ALU_SUB   = 3'd1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    // Control outputs that depend only on the state.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ior_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic       halted;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t            state, state_next;
    ctrl_t             ctrl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instr_count;
    logic              illegal_q, mem_err_q, branch_lt;
    logic              mem_wait, timeout, retire, trap;
    logic [3:0]        opcode;
    logic [2:0]        funct;
    logic              unused_instr_bits;

    assign opcode            = input_instr[INSTR_W-1 -: 4];
    assign funct             = input_instr[2:0];
    assign unused_instr_bits = ^input_instr[INSTR_W-5:3];

    // State-only control word for a given state.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRC_B_TWO; end
            S_DECODE: c.alu_src_b = SRC_B_IMM;
            S_EXEC_R: begin c.alu_src_a = SRC_A_REG; c.alu_op = f; end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = SRC_A_REG;
                c.alu_src_b = SRC_B_IMM;
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_MEM_RD: begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
            S_MEM_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR: begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = SRC_A_REG;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 1'b1;
            end
            S_JUMP:   c.pc_src = 1'b1;
            S_HALT:   c.halted = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    // Next-state selection, retire strobe and memory timeout detection.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_next = state;
        retire     = 1'b0;
        trap       = 1'b0;
        mem_wait   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        timeout    = mem_wait && !input_mem_ready && (wait_cnt == WAIT_LAST);
        case (state)
            S_FETCH:    if (input_mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = S_EXEC_R;
                    OP_ADDI:       state_next = S_EXEC_I;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BLT: state_next = S_BRANCH;
                    OP_JMP:        state_next = S_JUMP;
                    OP_HALT:       state_next = S_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_next = S_HALT;
                        trap       = 1'b1;
`else
                        state_next = S_FETCH;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
            S_ALU_WB:   begin state_next = S_FETCH; retire = 1'b1; end
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (input_mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:   begin state_next = S_FETCH; retire = 1'b1; end
            S_MEM_WR:   if (input_mem_ready) begin state_next = S_FETCH; retire = 1'b1; end
            S_BRANCH, S_JUMP: begin state_next = S_FETCH; retire = 1'b1; end
            default:    state_next = S_HALT;
        endcase
        // A ready on the timeout cycle wins, because timeout requires ready low.
        if (timeout) state_next = S_HALT;
    end

    // State register, registered control word, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            ctrl_q      <= ctrl_for(S_FETCH, 3'd0);
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            branch_lt   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state  <= state_next;
            ctrl_q <= ctrl_for(state_next, funct);
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_wait && !input_mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire)  instr_count <= instr_count + CNT_W'(1);
            if (timeout) mem_err_q   <= 1'b1;
            if (trap)    illegal_q   <= 1'b1;
            if (state == S_DECODE) branch_lt <= (opcode == OP_BLT);
        end
    end

    // The enables that depend on same-cycle inputs are combinational.
    // Every enable and select is forced to 0 while reset is high.
    assign output_PCWrite = !reset && (((state == S_FETCH) && input_mem_ready) ||
                                       (state == S_JUMP) ||
                                       ((state == S_BRANCH) &&
                                        (branch_lt ? input_negative : input_Zero)));
    assign output_IRWrite = !reset && (state == S_FETCH) && input_mem_ready;

    assign output_MemRead     = !reset && ctrl_q.mem_read;
    assign output_MemWrite    = !reset && ctrl_q.mem_write;
    assign output_IorD        = !reset && ctrl_q.ior_d;
    assign output_RegWrite    = !reset && ctrl_q.reg_write;
    assign output_MemtoReg    = !reset && ctrl_q.mem_to_reg;
    assign output_PCSrc       = !reset && ctrl_q.pc_src;
    assign output_halted      = !reset && ctrl_q.halted;
    assign output_ALUSrcA     = reset ? 2'd0 : ctrl_q.alu_src_a;
    assign output_ALUSrcB     = reset ? 2'd0 : ctrl_q.alu_src_b;
    assign output_ALUOp       = reset ? 3'd0 : ctrl_q.alu_op;
    assign output_illegal     = illegal_q;
    assign output_mem_err     = mem_err_q;
    assign output_instr_count = instr_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Builds, for each instruction, the expected per-cycle control sequence from
//   the instruction-level rules. It then drives the inputs and compares every
//   output on every cycle. The retired counter is narrowed to 4 bits so that
//   it wraps. Honours CTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_control_fsm;

    localparam int T  = 255;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   input_instr = '0;
    logic          input_Zero = 1'b0, input_negative = 1'b0, input_mem_ready = 1'b0;
    logic          output_PCWrite, output_IRWrite, output_IorD, output_MemRead;
    logic          output_MemWrite, output_RegWrite, output_MemtoReg, output_PCSrc;
    logic [1:0]    output_ALUSrcA, output_ALUSrcB;
    logic [2:0]    output_ALUOp;
    logic          output_halted, output_illegal, output_mem_err;
    logic [CW-1:0] output_instr_count;

    multicycle_control_fsm #(.INSTR_W(16), .CNT_W(CW), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .input_instr(input_instr),
        .input_Zero(input_Zero), .input_negative(input_negative),
        .input_mem_ready(input_mem_ready),
        .output_PCWrite(output_PCWrite), .output_IRWrite(output_IRWrite),
        .output_IorD(output_IorD), .output_MemRead(output_MemRead),
        .output_MemWrite(output_MemWrite), .output_RegWrite(output_RegWrite),
        .output_MemtoReg(output_MemtoReg), .output_ALUSrcA(output_ALUSrcA),
        .output_ALUSrcB(output_ALUSrcB), .output_ALUOp(output_ALUOp),
        .output_PCSrc(output_PCSrc), .output_halted(output_halted),
        .output_illegal(output_illegal), .output_mem_err(output_mem_err),
        .output_instr_count(output_instr_count)
    );

    always #5 clk = ~clk;

    // One expected cycle: the inputs to drive plus every output required.
    typedef struct packed {
        logic rdy, zero, neg;
        logic pcw, irw, iord, mrd, mwr, rw, m2r, pcsrc, halted, illegal, memerr;
        logic [1:0] sa, sb;
        logic [2:0] op;
        logic [CW-1:0] cnt;
    } cyc_t;

    cyc_t q[$];
    int   m_cnt = 0;
    bit   m_ill = 0, m_err = 0, m_halt = 0;
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare(input cyc_t e, input string tag);
        check({tag, ".PCWrite"},  output_PCWrite,     e.pcw);
        check({tag, ".IRWrite"},  output_IRWrite,     e.irw);
        check({tag, ".IorD"},     output_IorD,        e.iord);
        check({tag, ".MemRead"},  output_MemRead,     e.mrd);
        check({tag, ".MemWrite"}, output_MemWrite,    e.mwr);
        check({tag, ".RegWrite"}, output_RegWrite,    e.rw);
        check({tag, ".MemtoReg"}, output_MemtoReg,    e.m2r);
        check({tag, ".ALUSrcA"},  output_ALUSrcA,     e.sa);
        check({tag, ".ALUSrcB"},  output_ALUSrcB,     e.sb);
        check({tag, ".ALUOp"},    output_ALUOp,       e.op);
        check({tag, ".PCSrc"},    output_PCSrc,       e.pcsrc);
        check({tag, ".halted"},   output_halted,      e.halted);
        check({tag, ".illegal"},  output_illegal,     e.illegal);
        check({tag, ".mem_err"},  output_mem_err,     e.memerr);
        check({tag, ".count"},    output_instr_count, e.cnt);
    endtask

    // Idle cycle: no enables, random don't-care inputs, current model flags.
    function automatic cyc_t blank();
        cyc_t c;
        c = '0;
        c.rdy = 1'($urandom_range(0, 1));
        c.zero = 1'($urandom_range(0, 1));
        c.neg = 1'($urandom_range(0, 1));
        c.halted = m_halt;
        c.illegal = m_ill;
        c.memerr = m_err;
        c.cnt = CW'(m_cnt);
        return c;
    endfunction

    function automatic void retire();
        m_cnt = (m_cnt + 1) % (1 << CW);
    endfunction

    // A memory access of 'lat' not-ready cycles, then one ready cycle.
    // If 'lat' reaches the timeout, the access fails and the model halts.
    task automatic add_wait(input cyc_t base, input int lat, input bit fetch, output bit ok);
        cyc_t c;
        for (int i = 0; i < lat && i < T; i++) begin
            c = base; c.rdy = 1'b0; q.push_back(c);
        end
        if (lat >= T) begin
            m_err = 1; m_halt = 1; ok = 0;
        end else begin
            c = base; c.rdy = 1'b1;
            if (fetch) begin c.pcw = 1'b1; c.irw = 1'b1; end
            q.push_back(c);
            ok = 1;
        end
    endtask

    task automatic build(input logic [15:0] instr, input int flat, input int mlat, input bit brf);
        cyc_t c;
        bit   ok;
        q.delete();
        c = blank(); c.mrd = 1'b1; c.sb = 2'd1;
        add_wait(c, flat, 1'b1, ok);
        if (ok) begin
            c = blank(); c.sb = 2'd2; q.push_back(c);
            case (instr[15:12])
                4'h0, 4'h1: begin
                    c = blank(); c.sa = 2'd2;
                    if (instr[15:12] == 4'h0) c.op = instr[2:0]; else c.sb = 2'd2;
                    q.push_back(c);
                    c = blank(); c.rw = 1'b1; q.push_back(c); retire();
                end
                4'h2, 4'h3: begin
                    c = blank(); c.sa = 2'd2; c.sb = 2'd2; q.push_back(c);
                    c = blank(); c.iord = 1'b1;
                    if (instr[15:12] == 4'h2) c.mrd = 1'b1; else c.mwr = 1'b1;
                    add_wait(c, mlat, 1'b0, ok);
                    if (ok) begin
                        if (instr[15:12] == 4'h2) begin
                            c = blank(); c.rw = 1'b1; c.m2r = 1'b1; q.push_back(c);
                        end
                        retire();
                    end
                end
                4'h4, 4'h5: begin
                    c = blank(); c.sa = 2'd2; c.op = 3'd1; c.pcsrc = 1'b1;
                    if (instr[15:12] == 4'h4) c.zero = brf; else c.neg = brf;
                    c.pcw = brf;
                    q.push_back(c); retire();
                end
                4'h6: begin
                    c = blank(); c.pcsrc = 1'b1; c.pcw = 1'b1; q.push_back(c); retire();
                end
                4'hF: m_halt = 1;
                default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    m_ill = 1; m_halt = 1;
`else
                    retire();
`endif
                end
            endcase
        end
        if (m_halt) repeat (3) q.push_back(blank());
    endtask

    // Each entry covers one negedge-to-negedge window. Inputs are driven at
    // the negedge and outputs are compared 1 ns later.
    task automatic play(input int abort_at);
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) break;
            input_mem_ready = q[i].rdy;
            input_Zero      = q[i].zero;
            input_negative  = q[i].neg;
            #1 compare(q[i], $sformatf("i%04h_c%0d", input_instr, i));
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [15:0] instr, input int flat, input int mlat,
                       input bit brf, input int abort_at);
        input_instr = instr;
        build(instr, flat, mlat, brf);
        play(abort_at);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_cnt = 0; m_ill = 0; m_err = 0; m_halt = 0;
        #1 compare(blank(), "reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] instr;
        logic [3:0]  opc;
        int          r, abort_at;
        @(negedge clk);
        do_reset();

        // Reset asserted in DECODE, then a clean fetch afterwards.
        run(16'h0120, 0, 0, 0, 1);
        do_reset();
        // ADD R-type: retires once.
        run(16'h0120, 0, 0, 0, -1);
        check("lit_count_after_add", output_instr_count, 1);
        // LW with memory not ready for 3 cycles.
        run(16'h2345, 2, 3, 0, -1);
        check("lit_count_after_lw", output_instr_count, 2);
        // Branches.
        run(16'h4000, 0, 0, 1, -1);
        run(16'h4000, 1, 0, 0, -1);
        run(16'h5000, 0, 0, 1, -1);
        run(16'h5000, 0, 0, 0, -1);
        run(16'h6ABC, 0, 0, 0, -1);
        run(16'h3111, 0, 4, 0, -1);
        // A ready on the last allowed wait cycle completes the access.
        run(16'h2000, T - 1, T - 1, 0, -1);
        check("lit_no_err_at_boundary", output_mem_err, 0);
        // Fetch timeout.
        run(16'h0000, T, 0, 0, -1);
        check("lit_halted_after_timeout", output_halted, 1);
        check("lit_mem_err_after_timeout", output_mem_err, 1);
        do_reset();
        // Store timeout.
        run(16'h3000, 0, T, 0, -1);
        do_reset();
        // Illegal opcode 0x9.
        run(16'h9000, 0, 0, 0, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("lit_illegal_trap", output_illegal, 1);
        check("lit_illegal_halt", output_halted, 1);
`else
        check("lit_illegal_nop_count", output_instr_count, 1);
        check("lit_illegal_flag_zero", output_illegal, 0);
`endif
        if (m_halt) do_reset();
        // HALT opcode.
        run(16'hF000, 0, 0, 0, -1);
        do_reset();
        // Counter wrap: 18 ADDIs through a 4-bit counter.
        for (int k = 0; k < 18; k++) run(16'h1000 | 16'(k), k % 3, 0, 0, -1);
        check("lit_count_wrapped", output_instr_count, 18 % 16);

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       opc = 4'h0;
            else if (r < 6)  opc = 4'h1;
            else if (r < 9)  opc = 4'h2;
            else if (r < 12) opc = 4'h3;
            else if (r < 14) opc = 4'h4;
            else if (r < 16) opc = 4'h5;
            else if (r < 18) opc = 4'h6;
            else if (r < 19) opc = 4'hF;
            else             opc = 4'($urandom_range(7, 14));
            instr = {opc, 12'($urandom)};
            input_instr = instr;
            build(instr, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, q.size() - 1) : -1;
            play(abort_at);
            if (m_halt || abort_at >= 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
